// File: rtl/bsg_div_iterative_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package bsg_div_iterative_pkg;

   typedef enum logic [1:0] {
      eIDLE,
      eCAL,
      eADJ,
      eDONE
   } state_e;

   localparam int unsigned MaxWidth = 128;

   // All-ones quotient reported for a zero divisor; callers slice to their width.
   function automatic logic [MaxWidth-1:0] div_zero_quotient(input int unsigned width);
      logic [MaxWidth-1:0] q;
      q = '0;
      for (int unsigned i = 0; i < MaxWidth; i++) begin
         if (i < width) q[i] = 1'b1;
      end
      return q;
   endfunction

endpackage

// File: rtl/bsg_div_iterative_step.sv
// One combinational radix-2 restoring division step on magnitudes.
module bsg_div_iterative_step #(
   parameter int unsigned width_p = 32
) (
   input  logic [width_p-1:0] rem_i,
   input  logic               dvd_bit_i,
   input  logic [width_p-1:0] divisor_i,
   output logic [width_p-1:0] rem_o,
   output logic               q_bit_o
);

   logic [width_p:0]   shifted;
   logic [width_p-1:0] diff;

   // The shifted remainder can need width_p+1 bits for large unsigned divisors.
   assign shifted = {rem_i, dvd_bit_i};
   assign q_bit_o = (shifted >= {1'b0, divisor_i});
   assign diff    = shifted[width_p-1:0] - divisor_i;
   assign rem_o   = q_bit_o ? diff : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_div_iterative_restoring.sv
// Iterative radix-2 restoring divider, signed or unsigned, ready/valid in, valid/yumi out.
// Optional BSG_DIV_ITERATIVE_ZERO_EARLY_OUT_EN skips iteration on a zero divisor.
module bsg_div_iterative_restoring
   import bsg_div_iterative_pkg::*;
#(
   parameter int unsigned width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] dividend_i,
   input  logic [width_p-1:0] divisor_i,
   input  logic               signed_i,
   output logic               v_o,
   input  logic               yumi_i,
   output logic [width_p-1:0] quotient_o,
   output logic [width_p-1:0] remainder_o
);

   localparam int unsigned cnt_width_lp = $clog2(width_p);

   state_e                  state_q, state_d;
   logic [cnt_width_lp-1:0] cnt_q, cnt_d;
   logic [width_p-1:0]      dvd_q, dvd_d;
   logic [width_p-1:0]      rem_q, rem_d;
   logic [width_p-1:0]      dsr_q, dsr_d;
   logic                    neg_quot_q, neg_quot_d;
   logic                    neg_rem_q, neg_rem_d;
   logic                    zero_q, zero_d;

   logic                    a_neg, b_neg;
   logic [width_p-1:0]      a_abs, b_abs;
   logic [width_p-1:0]      step_rem;
   logic                    step_q;

   // Magnitude of the most negative value wraps to 2^(w-1), still correct as unsigned.
   assign a_neg = signed_i & dividend_i[width_p-1];
   assign b_neg = signed_i & divisor_i[width_p-1];
   assign a_abs = a_neg ? ('0 - dividend_i) : dividend_i;
   assign b_abs = b_neg ? ('0 - divisor_i) : divisor_i;

   bsg_div_iterative_step #(
      .width_p(width_p)
   ) u_step (
      .rem_i    (rem_q),
      .dvd_bit_i(dvd_q[width_p-1]),
      .divisor_i(dsr_q),
      .rem_o    (step_rem),
      .q_bit_o  (step_q)
   );

`ifdef BSG_DIV_ITERATIVE_ZERO_EARLY_OUT_EN
   logic [MaxWidth-1:0] zero_quot;
   assign zero_quot = div_zero_quotient(width_p);
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      rem_d      = rem_q;
      dsr_d      = dsr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      zero_d     = zero_q;
      ready_o    = 1'b0;
      v_o        = 1'b0;

      case (state_q)
         eIDLE: begin
            ready_o = 1'b1;
            if (v_i) begin
               dvd_d      = a_abs;
               rem_d      = '0;
               dsr_d      = b_abs;
               neg_quot_d = signed_i & (dividend_i[width_p-1] ^ divisor_i[width_p-1]);
               neg_rem_d  = a_neg;
               zero_d     = (divisor_i == '0);
               state_d    = eCAL;
`ifdef BSG_DIV_ITERATIVE_ZERO_EARLY_OUT_EN
               // Preload the final magnitudes and let eADJ restore the dividend's sign.
               if (divisor_i == '0) begin
                  dvd_d   = zero_quot[width_p-1:0];
                  rem_d   = a_abs;
                  state_d = eADJ;
               end
`endif
            end
         end
         eCAL: begin
            dvd_d = {dvd_q[width_p-2:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q + cnt_width_lp'(1);
            if (cnt_q == cnt_width_lp'(width_p - 1)) begin
               cnt_d   = '0;
               state_d = eADJ;
            end
         end
         eADJ: begin
            if (neg_quot_q && !zero_q) dvd_d = '0 - dvd_q;
            if (neg_rem_q)             rem_d = '0 - rem_q;
            state_d = eDONE;
         end
         eDONE: begin
            v_o = 1'b1;
            if (yumi_i) state_d = eIDLE;
         end
         default: state_d = eIDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= eIDLE;
         cnt_q      <= '0;
         dvd_q      <= '0;
         rem_q      <= '0;
         dsr_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         rem_q      <= rem_d;
         dsr_q      <= dsr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         zero_q     <= zero_d;
      end
   end

   assign quotient_o  = dvd_q;
   assign remainder_o = rem_q;

   yumi_only_when_done: assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> (state_q == eDONE));

endmodule
